// File: rtl/meta_write_responder_if.sv
// Request/array/ack signal bundle between the meta write arbiter and its responder.
interface meta_write_responder_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned WAY_W = 1,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             io_req_ready;
  logic             io_req_valid;
  logic [IDX_W-1:0] io_req_bits_idx;
  logic [WAY_W-1:0] io_req_bits_way_en;
  logic [TAG_W-1:0] io_req_bits_tag;
  logic             io_req_chosen;
  logic             io_array_wen;
  logic             io_array_ready;
  logic [IDX_W-1:0] io_array_idx;
  logic [WAY_W-1:0] io_array_way_en;
  logic [TAG_W-1:0] io_array_tag;
  logic             io_ack_0;
  logic             io_ack_1;
  logic             io_busy;
  logic [CNT_W-1:0] io_count;

  modport slave (
    output io_req_ready,
    input  io_req_valid, io_req_bits_idx, io_req_bits_way_en, io_req_bits_tag, io_req_chosen,
    output io_array_wen, io_array_idx, io_array_way_en, io_array_tag,
    input  io_array_ready,
    output io_ack_0, io_ack_1, io_busy, io_count
  );

  modport master (
    input  io_req_ready,
    output io_req_valid, io_req_bits_idx, io_req_bits_way_en, io_req_bits_tag, io_req_chosen,
    input  io_array_wen, io_array_idx, io_array_way_en, io_array_tag,
    output io_array_ready,
    input  io_ack_0, io_ack_1, io_busy, io_count
  );
endinterface

// File: rtl/meta_write_responder.sv
// In-order FIFO responder for dcache meta writes: drives the tag array and acks the source.
// Optional META_WRITE_COALESCE_EN merges same idx/way requests into the youngest entry.
module meta_write_responder #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned WAY_W = 1,
  parameter int unsigned TAG_W = 20,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  meta_write_responder_if.slave io
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef META_WRITE_COALESCE_EN
  localparam int unsigned SRC_W = 2;
`else
  localparam int unsigned SRC_W = 1;
`endif

  // src is a per-source ack mask when coalescing, otherwise the chosen bit
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WAY_W-1:0] way_en;
    logic [TAG_W-1:0] tag;
    logic [SRC_W-1:0] src;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             ready_q, busy_q, ack0_q, ack1_q;

  entry_t           head_e_c, req_e_c;
  logic             complete_c, push_c, merge_c, alloc_c;
  logic [CNT_W-1:0] count_d;
`ifdef META_WRITE_COALESCE_EN
  logic [PTR_W-1:0] young_ptr_c;
  entry_t           young_e_c;
`endif

  // next-state: accept/complete/merge decisions and occupancy
  always_comb begin
    complete_c     = busy_q & io.io_array_ready;
    push_c         = io.io_req_valid & ready_q;
    head_e_c       = mem_q[head_q];
    req_e_c.idx    = io.io_req_bits_idx;
    req_e_c.way_en = io.io_req_bits_way_en;
    req_e_c.tag    = io.io_req_bits_tag;
`ifdef META_WRITE_COALESCE_EN
    young_ptr_c    = tail_q - PTR_W'(1);
    young_e_c      = mem_q[young_ptr_c];
    req_e_c.src    = io.io_req_chosen ? 2'b10 : 2'b01;
    // youngest is the head when count==1; never merge into an entry leaving this cycle
    merge_c        = push_c & busy_q
                   & (young_e_c.idx == req_e_c.idx)
                   & (young_e_c.way_en == req_e_c.way_en)
                   & ~(complete_c & (count_q == CNT_W'(1)));
`else
    req_e_c.src    = io.io_req_chosen;
    merge_c        = 1'b0;
`endif
    alloc_c        = push_c & ~merge_c;
    count_d        = count_q + CNT_W'(alloc_c) - CNT_W'(complete_c);
  end

  // pointers, occupancy flags and ack pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      head_q  <= head_q + PTR_W'(complete_c);
      tail_q  <= tail_q + PTR_W'(alloc_c);
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(DEPTH));
      busy_q  <= (count_d != '0);
`ifdef META_WRITE_COALESCE_EN
      ack0_q  <= complete_c & head_e_c.src[0];
      ack1_q  <= complete_c & head_e_c.src[1];
`else
      ack0_q  <= complete_c & ~head_e_c.src[0];
      ack1_q  <= complete_c & head_e_c.src[0];
`endif
    end
  end

  // entry storage; contents are only observed while busy, so no reset
  always_ff @(posedge clock) begin
    if (alloc_c) mem_q[tail_q] <= req_e_c;
`ifdef META_WRITE_COALESCE_EN
    if (merge_c) begin
      mem_q[young_ptr_c].tag <= req_e_c.tag;
      mem_q[young_ptr_c].src <= young_e_c.src | req_e_c.src;
    end
`endif
  end

  assign io.io_req_ready    = ready_q;
  assign io.io_array_wen    = busy_q;
  assign io.io_array_idx    = busy_q ? head_e_c.idx    : '0;
  assign io.io_array_way_en = busy_q ? head_e_c.way_en : '0;
  assign io.io_array_tag    = busy_q ? head_e_c.tag    : '0;
  assign io.io_ack_0        = ack0_q;
  assign io.io_ack_1        = ack1_q;
  assign io.io_busy         = busy_q;
  assign io.io_count        = count_q;
endmodule

// File: tb/tb_meta_write_responder.sv
// Randomized + directed bench for meta_write_responder against a queue-based reference model.
module tb_meta_write_responder;
  localparam int unsigned DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  meta_write_responder_if #(.IDX_W(6), .WAY_W(1), .TAG_W(20), .DEPTH(DEPTH)) bus ();

  meta_write_responder #(.IDX_W(6), .WAY_W(1), .TAG_W(20), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic        way;
    logic [19:0] tag;
    logic [1:0]  mask;
  } ent_t;

  ent_t        q[$];
  logic        exp_ack0 = 1'b0, exp_ack1 = 1'b0;
  int          checks = 0, errors = 0;
  int          acks_seen = 0;
  logic [19:0] obs_tags[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("ready", 32'(bus.io_req_ready), 32'(q.size() < DEPTH));
    check("wen",   32'(bus.io_array_wen), 32'(q.size() != 0));
    check("busy",  32'(bus.io_busy),      32'(q.size() != 0));
    check("count", 32'(bus.io_count),     32'(q.size()));
    check("ack0",  32'(bus.io_ack_0),     32'(exp_ack0));
    check("ack1",  32'(bus.io_ack_1),     32'(exp_ack1));
    if (q.size() != 0) begin
      check("a_idx", 32'(bus.io_array_idx),    32'(q[0].idx));
      check("a_way", 32'(bus.io_array_way_en), 32'(q[0].way));
      check("a_tag", 32'(bus.io_array_tag),    32'(q[0].tag));
    end
    acks_seen += int'(bus.io_ack_0) + int'(bus.io_ack_1);
  endtask

  // Reference: a completion pops the oldest entry, acks follow one cycle later
  task automatic model_update(input logic v, input logic [5:0] i, input logic w,
                              input logic [19:0] t, input logic c, input logic ar);
    logic comp, acc, merged;
    logic [1:0] m;
    int last;
    if (!reset) begin
      q.delete();
      exp_ack0 = 1'b0;
      exp_ack1 = 1'b0;
      return;
    end
    comp     = (q.size() != 0) && ar;
    acc      = v && (q.size() < DEPTH);
    exp_ack0 = comp && q[0].mask[0];
    exp_ack1 = comp && q[0].mask[1];
    m        = c ? 2'b10 : 2'b01;
    merged   = 1'b0;
    if (acc) begin
`ifdef META_WRITE_COALESCE_EN
      last = q.size() - 1;
      if (q.size() != 0 && q[last].idx == i && q[last].way == w && !(comp && q.size() == 1)) begin
        q[last].tag  = t;
        q[last].mask = q[last].mask | m;
        merged       = 1'b1;
      end
`endif
      if (!merged) q.push_back('{idx: i, way: w, tag: t, mask: m});
    end
    if (comp) void'(q.pop_front());
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge
  task automatic cycle(input logic v, input logic [5:0] i, input logic w,
                       input logic [19:0] t, input logic c, input logic ar);
    bus.io_req_valid       = v;
    bus.io_req_bits_idx    = i;
    bus.io_req_bits_way_en = w;
    bus.io_req_bits_tag    = t;
    bus.io_req_chosen      = c;
    bus.io_array_ready     = ar;
    if (bus.io_array_wen && ar) obs_tags.push_back(bus.io_array_tag);
    @(posedge clock);
    model_update(v, i, w, t, c, ar);
    @(negedge clock);
    check_outputs();
  endtask

  initial begin
    bus.io_req_valid = 1'b0; bus.io_req_bits_idx = '0; bus.io_req_bits_way_en = '0;
    bus.io_req_bits_tag = '0; bus.io_req_chosen = 1'b0; bus.io_array_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs();
    check("rst_tag", 32'(bus.io_array_tag), 32'h0);
    reset = 1'b1;
    cycle(0, 0, 0, 0, 0, 0);

    // single request
    cycle(1, 6'h2A, 1, 20'hABCDE, 1, 1);
    check("t1_tag", 32'(bus.io_array_tag), 32'hABCDE);
    check("t1_idx", 32'(bus.io_array_idx), 32'h2A);
    cycle(0, 0, 0, 0, 0, 1);
    check("t1_ack1", 32'(bus.io_ack_1), 32'h1);
    check("t1_ack0", 32'(bus.io_ack_0), 32'h0);
    check("t1_cnt",  32'(bus.io_count), 32'h0);
    cycle(0, 0, 0, 0, 0, 1);

    // back-pressure fills the FIFO
    cycle(1, 6'h01, 1, 20'h00111, 0, 0);
    cycle(1, 6'h02, 1, 20'h00222, 1, 0);
    check("t2_cnt",   32'(bus.io_count),     32'h2);
    check("t2_ready", 32'(bus.io_req_ready), 32'h0);
    cycle(1, 6'h05, 1, 20'h00555, 0, 0);
    check("t2_hold",  32'(bus.io_array_tag), 32'h00111);
    cycle(0, 0, 0, 0, 0, 1);
    check("t2_rdy1",  32'(bus.io_req_ready), 32'h1);
    check("t2_ackA",  32'(bus.io_ack_0),     32'h1);
    cycle(0, 0, 0, 0, 0, 1);
    check("t2_ackB",  32'(bus.io_ack_1),     32'h1);
    cycle(0, 0, 0, 0, 0, 1);

    // enqueue and complete together at count=1
    cycle(1, 6'h07, 0, 20'h00777, 0, 0);
    cycle(1, 6'h08, 0, 20'h00888, 1, 1);
    check("t3_cnt", 32'(bus.io_count),     32'h1);
    check("t3_tag", 32'(bus.io_array_tag), 32'h00888);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    // wrap-around streaming
    obs_tags.delete();
    acks_seen = 0;
    for (int k = 1; k <= 5; k++) cycle(1, 6'(k + 16), 0, 20'(k), 1'(k % 2), 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    check("t4_nacks", 32'(acks_seen), 32'd5);
    check("t4_ntags", 32'(obs_tags.size()), 32'd5);
    for (int k = 0; k < 5 && k < obs_tags.size(); k++) check("t4_tag", 32'(obs_tags[k]), 32'(k + 1));

    // reset while holding two entries
    cycle(1, 6'h09, 0, 20'h00999, 0, 0);
    cycle(1, 6'h0A, 0, 20'h00AAA, 1, 0);
    reset = 1'b0;
    #1;
    check("t5_cnt",   32'(bus.io_count),     32'h0);
    check("t5_wen",   32'(bus.io_array_wen), 32'h0);
    check("t5_ready", 32'(bus.io_req_ready), 32'h1);
    cycle(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    acks_seen = 0;
    repeat (3) cycle(0, 0, 0, 0, 0, 1);
    check("t5_noack", 32'(acks_seen), 32'h0);

`ifdef META_WRITE_COALESCE_EN
    cycle(1, 6'h03, 0, 20'h00010, 0, 0);
    cycle(1, 6'h03, 0, 20'h00020, 1, 0);
    check("t6_cnt", 32'(bus.io_count),     32'h1);
    check("t6_tag", 32'(bus.io_array_tag), 32'h00020);
    cycle(0, 0, 0, 0, 0, 1);
    check("t6_ack0", 32'(bus.io_ack_0), 32'h1);
    check("t6_ack1", 32'(bus.io_ack_1), 32'h1);
    cycle(0, 0, 0, 0, 0, 1);
`endif

    // random traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        reset = 1'b0;
        cycle(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
      end
      cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            20'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (4) cycle(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/meta_write_responder.md
Name: meta_write_responder

Overview:
- Responder end of the 2-source metadata-write request stream (idx / way_en / tag plus chosen-source id) that the dcache meta write arbiter produces.
- Buffers accepted requests in a small in-order FIFO and drives the tag-array write port, honouring array back-pressure.
- Returns a registered one-cycle acknowledge pulse to the originating source once its write has been committed to the array.

Parameters:
- IDX_W, 6, set-index width
- WAY_W, 1, way-enable width
- TAG_W, 20, tag width
- DEPTH, 2, FIFO entries; power of two, >=2

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- io_req_ready  out  1  FIFO can accept a request
- io_req_valid  in  1  request present
- io_req_bits_idx  in  IDX_W  set index
- io_req_bits_way_en  in  WAY_W  way enable
- io_req_bits_tag  in  TAG_W  tag to write
- io_req_chosen  in  1  originating source (0 or 1)
- io_array_wen  out  1  array write request
- io_array_ready  in  1  array accepts the write this cycle
- io_array_idx  out  IDX_W  write index
- io_array_way_en  out  WAY_W  write way mask
- io_array_tag  out  TAG_W  write data
- io_ack_0  out  1  one-cycle pulse: a source-0 write has completed
- io_ack_1  out  1  one-cycle pulse: a source-1 write has completed
- io_busy  out  1  FIFO non-empty
- io_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: the FIFO is empty (head/tail/count = 0). All outputs are 0, except io_req_ready = 1.
- Asserting reset mid-operation discards all queued entries; no acks are issued for them.
- Enqueue:
  - io_req_ready = (count < DEPTH). It is registered-state derived only and has no combinational path from io_req_valid.
  - On io_req_valid & io_req_ready, {idx, way_en, tag, chosen} is written at the tail and the tail advances, wrapping modulo DEPTH.
- Array write:
  - io_array_wen = busy. io_array_idx, io_array_way_en and io_array_tag show the head entry.
  - A write completes on io_array_wen & io_array_ready. The head then advances, wrapping modulo DEPTH.
  - While io_array_ready = 0, the head outputs hold stable.
- Latency: a request accepted in cycle t can produce io_array_wen in cycle t+1 at the earliest. There is no flow-through.
- Occupancy update:
  - Enqueue and completion in the same cycle: count is unchanged. This is legal whenever count < DEPTH.
  - When full, io_req_ready = 0, even if a completion occurs in that cycle. Ready rises the cycle after the completion.
- Ack: registered. In cycle c+1 after a completion in cycle c, pulse io_ack_0 if the completed entry's chosen = 0, else io_ack_1. Each pulse is one cycle wide.
- Back-to-back completions produce back-to-back ack pulses.
- Ordering: writes and acks occur strictly in acceptance order.
- io_busy = (count != 0). io_count equals the registered count.
- io_req_* inputs are ignored when io_req_valid = 0.

Optional Feature:
- Macro: META_WRITE_COALESCE_EN.
- Defined: each entry holds a 2-bit ack mask instead of a chosen bit. An accepted request coalesces into the youngest entry when all of the following hold:
  - count >= 1;
  - the request's idx and way_en equal that entry's;
  - that entry is not completing in the same cycle (i.e. not the head while io_array_wen & io_array_ready).
- On coalesce: the entry's tag is overwritten, the request's source bit is ORed into the mask, and count does not change.
- On completion of a coalesced entry, pulse io_ack_0 and/or io_ack_1 together, per the mask.
- io_req_ready rule is unchanged; coalescing never lets a full FIFO accept.
- Undefined: every accepted request occupies its own entry; behaviour is exactly as above.

Test Plan:
- Reset then single request: idx=0x2A, way_en=1, tag=0xABCDE, chosen=1, array_ready=1 -> wen in the next cycle with those values, io_ack_1 pulse one cycle later, io_ack_0 stays 0, count returns to 0.
- Back-pressure: array_ready=0, enqueue 2 requests -> count=2, io_req_ready=0, array outputs hold entry 0; release array_ready -> two consecutive completions, acks in enqueue order, ready=1 one cycle after the first completion.
- Simultaneous enqueue and completion at count=1 -> count stays 1; the new entry is written in the following cycle.
- Wrap-around: 5 requests streamed with array_ready=1, tags 0x1..0x5 -> array_tag sequence 0x1..0x5, 5 ack pulses, no loss or duplication.
- Reset asserted (reset=0) with count=2 -> immediately count=0, wen=0, ready=1; no acks for the dropped entries.
- COALESCE_EN: array_ready=0; req A (idx=3, tag=0x10, src 0), then req B (idx=3, tag=0x20, src 1) -> count=1; release -> single write with tag=0x20, io_ack_0 and io_ack_1 pulse in the same cycle.
